// File: rtl/md_pkg.sv
// Shared opcode encoding, state type and op-class helpers for the multiply/divide unit.
package md_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MADD  = 4'd5,
      OP_MADDU = 4'd6,
      OP_MSUB  = 4'd7,
      OP_MSUBU = 4'd8,
      OP_MTHI  = 4'd9,
      OP_MTLO  = 4'd10
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   // Ops that occupy the unit for several cycles (everything except moves and NONE).
   function automatic logic is_long_op(input md_op_t op);
      return (op >= OP_MULT) && (op <= OP_MSUBU);
   endfunction

   function automatic logic is_div_op(input md_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Ops whose operands are treated as two's complement.
   function automatic logic is_signed_op(input md_op_t op);
      return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath: computes the next {hi,lo} from the latched operands and current HI/LO.
module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_t           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt,
   output logic             div0
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2*WIDTH-1:0]       ext_a;
   logic [2*WIDTH-1:0]       ext_b;
   logic [2*WIDTH-1:0]       prod;
   logic [2*WIDTH-1:0]       acc;
   logic [2*WIDTH-1:0]       res;
   logic                     ovf;
   logic [WIDTH-1:0]         b_safe;
   logic signed [WIDTH-1:0]  sa;
   logic signed [WIDTH-1:0]  sb;
   logic signed [WIDTH-1:0]  q_s;
   logic signed [WIDTH-1:0]  r_s;
   logic [WIDTH-1:0]         q_u;
   logic [WIDTH-1:0]         r_u;

   // Product, quotient/remainder and accumulate result for the latched op.
   always_comb begin
      acc  = {hi, lo};
      div0 = is_div_op(op) && (b == '0);
      ovf  = (op == OP_DIV) && (a == MOST_NEG) && (b == '1);

      // Sign/zero-extend to 2*WIDTH so a plain unsigned multiply yields the exact product bits.
      if (is_signed_op(op)) begin
         ext_a = {{WIDTH{a[WIDTH-1]}}, a};
         ext_b = {{WIDTH{b[WIDTH-1]}}, b};
      end else begin
         ext_a = {{WIDTH{1'b0}}, a};
         ext_b = {{WIDTH{1'b0}}, b};
      end
      prod = ext_a * ext_b;

      // Divisor is forced to 1 for the zero and overflow cases; those results are overridden anyway.
      b_safe = (div0 || ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
      sa     = a;
      sb     = b_safe;
      q_s    = sa / sb;
      r_s    = sa % sb;
      q_u    = a / b_safe;
      r_u    = a % b_safe;

      case (op)
         OP_MULT, OP_MULTU: res = prod;
         OP_MADD, OP_MADDU: res = acc + prod;
         OP_MSUB, OP_MSUBU: res = acc - prod;
         OP_DIV:            res = ovf ? {{WIDTH{1'b0}}, MOST_NEG} : {r_s, q_s};
         OP_DIVU:           res = {r_u, q_u};
         default:           res = acc;
      endcase

      if (div0) begin
         res = acc;
      end

      hi_nxt = res[2*WIDTH-1:WIDTH];
      lo_nxt = res[WIDTH-1:0];
   end

endmodule

// File: rtl/md_unit_param.sv
// Multiply/divide unit owning HI/LO, with configurable width and per-class busy latency.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | counter = 0, accepts start (moves complete immediately)
//  ST_RUN  | long op in flight, counter counts down, hi/lo written on 1->0
module md_unit_param
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             md_hazard
);

   localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   md_op_t           op_cmd;
   md_op_t           op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;
   logic             div0;

   assign op_cmd    = md_op_t'(op);
   assign md_hazard = busy | (start & is_long_op(op_cmd));

   md_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi     (hi),
      .lo     (lo),
      .hi_nxt (hi_nxt),
      .lo_nxt (lo_nxt),
      .div0   (div0)
   );

   // Accept / count-down / commit sequencer; reset drops any op in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         op_q  <= OP_NONE;
         a_q   <= '0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (op_cmd == OP_MTHI) begin
                     hi <= a;
                  end else if (op_cmd == OP_MTLO) begin
                     lo <= a;
                  end else if (is_long_op(op_cmd)) begin
                     op_q  <= op_cmd;
                     a_q   <= a;
                     b_q   <= b;
                     cnt   <= is_div_op(op_cmd) ? DIV_N : MULT_N;
                     busy  <= 1'b1;
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                  if (!div0) begin
                     hi <= hi_nxt;
                     lo <= lo_nxt;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param: directed table, hand sequences, randomized ops vs model.
module tb_md_unit_param;
   import md_pkg::*;

   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         md_hazard;

   int           total = 0;
   int           bad   = 0;
   logic [63:0]  m_acc;

   typedef struct {
      md_op_t      op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[14];

   md_unit_param #(
      .WIDTH       (W),
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .md_hazard (md_hazard)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int exp_cycles(input md_op_t o);
      if (o == OP_DIV || o == OP_DIVU) return DC;
      if (o >= OP_MULT && o <= OP_MSUBU) return MC;
      return 0;
   endfunction

   // Architectural result from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [63:0] acc);
      longint      sx;
      longint      sy;
      longint      q;
      longint      r;
      logic [63:0] ux;
      logic [63:0] uy;
      sx = $signed(x);
      sy = $signed(y);
      ux = {32'h0, x};
      uy = {32'h0, y};
      case (o)
         OP_MULT:  return sx * sy;
         OP_MULTU: return ux * uy;
         OP_MADD:  return acc + (sx * sy);
         OP_MADDU: return acc + (ux * uy);
         OP_MSUB:  return acc - (sx * sy);
         OP_MSUBU: return acc - (ux * uy);
         OP_DIV: begin
            if (y == 32'h0) return acc;
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         OP_DIVU: begin
            if (y == 32'h0) return acc;
            return {x % y, x / y};
         end
         OP_MTHI:  return {x, acc[31:0]};
         OP_MTLO:  return {acc[63:32], x};
         default:  return acc;
      endcase
   endfunction

   // Issue one op, measure busy length, check HI/LO hold during busy and the final result.
   task automatic do_op(input md_op_t o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] expv, input string tag);
      int   cyc;
      logic hold_ok;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      #1;
      chk({tag, " hazard_start"}, 64'(md_hazard), 64'(exp_cycles(o) != 0));
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = OP_NONE;
      cyc     = 0;
      hold_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
         if ({hi, lo} !== m_acc) hold_ok = 1'b0;
      end
      chk({tag, " busy_cycles"}, 64'(cyc), 64'(exp_cycles(o)));
      chk({tag, " hold"}, 64'(hold_ok), 64'(1));
      chk({tag, " result"}, {hi, lo}, expv);
      chk({tag, " hazard_after"}, 64'(md_hazard), 64'(0));
      m_acc = expv;
   endtask

   initial begin
      int          cyc;
      md_op_t      ro;
      logic [31:0] ra;
      logic [31:0] rb;

      tbl = '{
         '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1},
         '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD},
         '{OP_DIVU,  32'h00000007, 32'h00000000, 64'hFFFFFFFF_FFFFFFFD},
         '{OP_MTLO,  32'h00000010, 32'h00000000, 64'hFFFFFFFF_00000010},
         '{OP_MTHI,  32'h00000000, 32'h00000000, 64'h00000000_00000010},
         '{OP_MADDU, 32'h00000002, 32'h00000003, 64'h00000000_00000016},
         '{OP_MSUB,  32'h00000001, 32'h00000017, 64'hFFFFFFFF_FFFFFFFF},
         '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000},
         '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001},
         '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF},
         '{OP_MADD,  32'hFFFFFFFF, 32'h00000002, 64'h0000000F_0FFFFFFD},
         '{OP_MSUBU, 32'hFFFFFFFF, 32'h00000001, 64'h0000000E_0FFFFFFE},
         '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD},
         '{OP_NONE,  32'h00000005, 32'h00000005, 64'h00000001_FFFFFFFD}
      };

      reset = 1'b1;
      start = 1'b0;
      op    = OP_NONE;
      a     = '0;
      b     = '0;
      m_acc = '0;
      repeat (2) @(negedge clk);
      chk("reset hilo", {hi, lo}, 64'h0);
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset hazard", 64'(md_hazard), 64'(0));
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 14; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
      end

      // Start while busy mid-DIV must be ignored (long op and a move)
      @(negedge clk);
      start = 1'b1;
      op    = OP_DIV;
      a     = 32'd100;
      b     = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = OP_NONE;
      cyc   = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
         if (cyc == 3) begin
            start = 1'b1;
            op    = OP_MULT;
            a     = 32'd3;
            b     = 32'd3;
            #1;
            chk("ign hazard_busy", 64'(md_hazard), 64'(1));
         end else if (cyc == 6) begin
            start = 1'b1;
            op    = OP_MTHI;
            a     = 32'hDEAD;
         end else begin
            start = 1'b0;
            op    = OP_NONE;
         end
      end
      start = 1'b0;
      op    = OP_NONE;
      chk("ign busy_cycles", 64'(cyc), 64'(DC));
      chk("ign result", {hi, lo}, 64'h00000002_0000000E);
      m_acc = 64'h00000002_0000000E;

      // Asynchronous reset in the middle of a MULT
      @(negedge clk);
      start = 1'b1;
      op    = OP_MULT;
      a     = 32'd6;
      b     = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = OP_NONE;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst busy", 64'(busy), 64'(0));
      chk("arst hilo", {hi, lo}, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      m_acc = '0;
      do_op(OP_MULT, 32'd2, 32'd2, 64'h4, "post_rst");

      // Randomized ops checked against the model
      for (int i = 0; i < 60; i++) begin
         ro = md_op_t'(4'($urandom_range(1, 10)));
         case ($urandom_range(0, 7))
            0:       ra = 32'h0;
            1:       ra = 32'h80000000;
            2:       ra = 32'hFFFFFFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 32'h0;
            1:       rb = 32'hFFFFFFFF;
            2:       rb = 32'h1;
            default: rb = $urandom;
         endcase
         do_op(ro, ra, rb, model(ro, ra, rb, m_acc), $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core. Sits in the E stage beside the ALU and owns the HI/LO registers.
- Replaces the fixed-latency MDU. Adds configurable width and per-class latency, the multiply-accumulate ops (madd/maddu/msub/msubu), and defined divide-by-zero and overflow handling.
- Exports `busy` and `md_hazard` to the stall controller.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu; range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  E-stage instruction is an MDU op; qualifies op.
- op  in  4  md_op_t opcode (see package).
- a  in  WIDTH  rs operand (forwarded value).
- b  in  WIDTH  rt operand (forwarded value).
- hi  out  WIDTH  HI register, read by mfhi.
- lo  out  WIDTH  LO register, read by mflo.
- busy  out  1  long operation in flight.
- md_hazard  out  1  combinational: busy | (start & op is a long op); the stall controller uses it to stall mfhi/mflo/MDU ops in D.

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, operand/op latches=0. Takes effect immediately, including mid-operation; the pending result is discarded.
- Accept rule: an op is accepted on an edge only when start=1 and busy=0. When busy=1, start is ignored entirely (MTHI/MTLO included); the controller must prevent this.
- MTHI/MTLO: on the accepting edge, hi<=a or lo<=a. No busy. Visible the next cycle.
- Long op, accepted at edge t:
  - latch a, b and op; counter<=N (MULT_CYCLES or DIV_CYCLES).
  - busy=1 for exactly N cycles following edge t.
  - Each edge decrements counter. On the edge where counter goes 1->0, hi/lo are written, so the result is visible the same cycle busy falls.
  - hi/lo hold their old values throughout busy.
- States: IDLE (counter=0) and RUN (counter>0). IDLE->RUN on a long op; RUN->IDLE on the final decrement. No back-to-back acceptance on the completing edge: a new op may be accepted on the first edge with busy=0.
- Arithmetic, with P = 2*WIDTH-bit product:
  - mult: signed(a)*signed(b). multu: unsigned product. {hi,lo}<=P.
  - madd/maddu: {hi,lo}<={hi,lo}+P. msub/msubu: {hi,lo}<={hi,lo}-P. Both modulo 2^(2*WIDTH). Signedness of P follows the op. The old {hi,lo} is sampled at completion.
  - div: lo<=signed quotient truncated toward zero; hi<=remainder with the sign of the dividend. divu: unsigned quotient/remainder.
  - Divide by zero (b=0): counts the full DIV_CYCLES; hi/lo unchanged.
  - Signed overflow (a=most-negative, b=-1): lo<=most-negative, hi<=0.
- op=NONE with start=1: no effect.

Decomposition:
- Package md_pkg:
  - md_op_t, 4-bit enum: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8, MTHI=9, MTLO=10.
  - Helper constants/functions for is_long_op and is_div_op.
  - CNT_W=4.
- One sub-module, md_arith: purely combinational. Takes the latched a, b, op and current hi/lo; returns next {hi,lo} plus a div0 flag. The top-level keeps the counter, latches and registers.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> busy high exactly 5 cycles; on busy fall hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged (prior 0) during busy.
- DIV a=0xFFFFFFF9(-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> busy 10 cycles, hi/lo keep prior values.
- MTLO a=0x10, MTHI a=0, then MADDU a=2, b=3 -> lo=0x16, hi=0; then MSUB a=1, b=0x17 -> {hi,lo}=0xFFFFFFFF_FFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Also start=1/op=MULT asserted while busy, mid-DIV -> ignored; DIV result is intact and busy timing is unchanged.
- md_hazard: high in the start cycle of MULT (busy still 0); low for MTHI start; low after completion.
- Reset asserted asynchronously at cycle 3 of a MULT -> busy=0, hi=lo=0 without waiting for a clock edge. After reset release, a new MULT 2*2 gives lo=4.
